// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump port: FSM state encoding and default arm bytes.
package debug_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_DUMP  = 3'd2,
      ST_REQ   = 3'd3,
      ST_WAIT  = 3'd4
   } state_t;

   localparam logic [7:0] MAGIC0_DEF = 8'h14;
   localparam logic [7:0] MAGIC1_DEF = 8'h01;

   // The CPU is stalled in every state past the arming handshake.
   function automatic logic halted(input state_t s);
      return !((s == ST_IDLE) || (s == ST_ARMED));
   endfunction

endpackage

// File: rtl/dbg_timeout.sv
// Saturating idle counter; expired flags the enabled cycle whose count reaches LIMIT.
module dbg_timeout #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LIM    = CW'(LIMIT);
   localparam logic [CW-1:0] LIM_M1 = CW'(LIMIT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIM)) begin
         count <= count + 1'b1;
      end
   end

   // Look one step ahead so the exit edge is the one that brings the count to LIMIT.
   assign expired = enable && !clear && (count >= LIM_M1);

endmodule

// File: rtl/debug_dump_port.sv
// Host byte-stream debug port: two-byte arm sequence, then one memory word read per address byte.
module debug_dump_port
   import debug_pkg::*;
#(
   parameter int         ADDR_W  = 8,
   parameter int         WORD_W  = 32,
   parameter logic [7:0] MAGIC0  = MAGIC0_DEF,
   parameter logic [7:0] MAGIC1  = MAGIC1_DEF,
   parameter int         IDLE_TO = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        cmd_byte,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic [WORD_W-1:0] data_out,
   output logic              rsp_valid,
   output logic              cpu_halt
);

   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   tmo_expired;

   assign cmd_ready = (state == ST_IDLE) || (state == ST_ARMED) || (state == ST_DUMP);
   assign accept    = cmd_valid && cmd_ready;
   assign mem_req   = (state == ST_REQ);
   assign cpu_halt  = halted(state);

   dbg_timeout #(
      .LIMIT (IDLE_TO)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   ((state != ST_DUMP) || accept),
      .enable  ((state == ST_DUMP) && !accept),
      .expired (tmo_expired)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept && (cmd_byte == MAGIC0)) state_nxt = ST_ARMED;
         end
         ST_ARMED: begin
            if (accept) begin
               if (cmd_byte == MAGIC1)      state_nxt = ST_DUMP;
               else if (cmd_byte == MAGIC0) state_nxt = ST_ARMED;
               else                         state_nxt = ST_IDLE;
            end
         end
         ST_DUMP: begin
            if (accept)           state_nxt = ST_REQ;
            else if (tmo_expired) state_nxt = ST_IDLE;
         end
         ST_REQ: begin
            if (mem_gnt) state_nxt = ST_WAIT;
         end
         ST_WAIT: state_nxt = ST_DUMP;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         mem_addr  <= '0;
         data_out  <= '0;
         rsp_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         rsp_valid <= (state == ST_WAIT);
         // Size cast truncates or zero-extends the byte to the address width.
         if ((state == ST_DUMP) && accept) mem_addr <= ADDR_W'(cmd_byte);
         if (state == ST_WAIT) data_out <= mem_rdata;
      end
   end

endmodule
